// File: rtl/conv_out_writer.sv
// Conv result writer: buffers engine results, tags end-of-row/frame, absorbs backpressure.
// Define CONV_OUT_RELU_EN to clamp negative results to zero on the push path.
module conv_out_writer #(
    parameter int DATA_W     = 16,
    parameter int ROW_LEN    = 12,
    parameter int ROWS       = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eor,
    output logic              out_eof,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_d [FIFO_DEPTH];
    logic              eor_q [FIFO_DEPTH];
    logic              eor_d [FIFO_DEPTH];
    logic              eof_q [FIFO_DEPTH];
    logic              eof_d [FIFO_DEPTH];

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              push_eor;
    logic              push_eof;
    logic [DATA_W-1:0] push_data;

    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign res_ready  = (state_q == COLLECT) && !full;
    assign out_valid  = !empty;
    assign out_data   = data_q[rd_ptr_q[AW-1:0]];
    assign out_eor    = eor_q[rd_ptr_q[AW-1:0]];
    assign out_eof    = eof_q[rd_ptr_q[AW-1:0]];
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    assign push     = res_valid && res_ready;
    assign pop      = out_valid && out_ready;
    assign push_eor = (col_q == CW'(ROW_LEN - 1));
    assign push_eof = push_eor && (row_q == RW'(ROWS - 1));

`ifdef CONV_OUT_RELU_EN
    assign push_data = res_data[DATA_W-1] ? '0 : res_data;
`else
    assign push_data = res_data;
`endif

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        data_d       = data_q;
        eor_d        = eor_q;
        eof_d        = eof_q;

        if (push) begin
            data_d[wr_ptr_q[AW-1:0]] = push_data;
            eor_d[wr_ptr_q[AW-1:0]]  = push_eor;
            eof_d[wr_ptr_q[AW-1:0]]  = push_eof;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (push_eor) begin
                col_d = '0;
                if (row_q != RW'(ROWS - 1)) begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COLLECT;
                    col_d      = '0;
                    row_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            COLLECT: begin
                if (res_valid && !res_ready) begin
                    overflow_d = 1'b1;
                end
                if (push && push_eof) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_eof) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                eor_q[i]  <= 1'b0;
                eof_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= data_d[i];
                eor_q[i]  <= eor_d[i];
                eof_q[i]  <= eof_d[i];
            end
        end
    end

endmodule
